mic_rsp_dmx: RTL and testbench
==============================

Name: mic_rsp_dmx

Overview:
- Return-path demultiplexer for the pooling memory-interface channel.
- Takes the single port-tagged response stream {port, ofm} produced by the request-side multi-core arbiter and routes each beat to the owning pool core.
- Each core has its own 2-entry FWFT buffer, so one stalled core never blocks the others beyond its buffer depth.
- Sits between the arbiter's output FIFO and the POOL_CORE pooling cores.

Parameters:
- POOL_CORE, 6, number of pool cores (response destinations).
- POOL_COMP_CORE, 64, activations per response beat.
- ACT_WIDTH, 8, bits per activation.
- MAX_OUTS, 4, maximum outstanding requests per core; used only with RSP_CREDIT_CHK_EN.
- Derived: PORT_W = $clog2(POOL_CORE) (3 by default).
- Derived: DW = ACT_WIDTH*POOL_COMP_CORE (512 by default).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- MICMIF_Ofm  in  PORT_W+DW  response beat; [PORT_W+DW-1:DW] = destination port tag, [DW-1:0] = data.
- MICMIF_OfmVld  in  1  response beat valid.
- MIFMIC_OfmRdy  out  1  demux accepts the beat.
- MIFPOL_Ofm  out  DW*POOL_CORE  per-core data; core i uses [DW*i +: DW].
- MIFPOL_OfmVld  out  POOL_CORE  per-core valid.
- POLMIF_OfmRdy  in  POOL_CORE  per-core ready.
- POLMIF_ReqAcc  in  POOL_CORE  per-core request-accepted pulse (AddrVld & Rdy on the request side); ignored unless RSP_CREDIT_CHK_EN.
- MIFPOL_DropCnt  out  8  saturating count of dropped beats.
- MIFPOL_Err  out  1  sticky error flag.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. While Reset=1 at a clock edge:
  - all buffers are emptied;
  - MIFPOL_OfmVld = 0;
  - MIFPOL_DropCnt = 0, MIFPOL_Err = 0;
  - credit counters = 0.
- Reset mid-transfer discards all buffered beats. No beat is accepted in a cycle where Reset=1, and MIFMIC_OfmRdy is forced to 0 during reset.
- Tag decode: tag t = MICMIF_Ofm[PORT_W+DW-1:DW].
  - If t >= POOL_CORE, the tag is invalid.
  - If t < POOL_CORE, the beat is routed to core t.
- MIFMIC_OfmRdy is combinational, from the tag and buffer state:
  - valid tag: !full[t];
  - invalid tag: 1 (beat is drained and dropped).
  - There is no dependence on a same-cycle pop: if buf[t] is full it is not ready, even when core t pops in that cycle.
- Accept: MICMIF_OfmVld & MIFMIC_OfmRdy.
  - Valid tag: the data is pushed to buf[t].
  - Invalid tag: the beat is dropped; DropCnt += 1 (saturates at 255); Err <= 1.
- Per-core buffer: 2-entry FWFT queue.
  - MIFPOL_OfmVld[i] = !empty[i].
  - MIFPOL_Ofm[i] = head entry, held stable while Vld=1 and Rdy=0.
  - Pop on MIFPOL_OfmVld[i] & POLMIF_OfmRdy[i].
  - Push and pop in the same cycle with 1 entry: count stays 1; the new head is the pushed beat.
- Latency: a beat accepted at edge k is visible on MIFPOL_OfmVld at cycle k+1 (no combinational in-to-out bypass).
- Ordering: beats to the same core are delivered in arrival order. No ordering is guaranteed across cores.
- Throughput: 1 beat/cycle in, while the destination core keeps up.
- Data outputs of an empty buffer are don't-care; the bench must not check them.

Optional Feature:
- Macro: RSP_CREDIT_CHK_EN.
- When defined:
  - Per-core outstanding counter oc[i], width $clog2(MAX_OUTS+1).
  - Increment on POLMIF_ReqAcc[i]; decrement on accept of a beat tagged i.
  - Increment and decrement in the same cycle: no change.
  - A valid-tag beat arriving with oc[t]=0 is treated as invalid: ready=1, dropped, DropCnt++, Err<=1.
  - Increment while oc[i]=MAX_OUTS: oc saturates and Err<=1.
- When not defined:
  - No counters are built.
  - POLMIF_ReqAcc is unused.
  - Only invalid tags cause drops.

Test Plan:
- Reset=1 for 2 cycles with MICMIF_OfmVld=1 -> MIFMIC_OfmRdy=0; all MIFPOL_OfmVld=0; DropCnt=0; Err=0.
- Beat tag=3, data=0xA5 repeated, all cores ready -> MIFPOL_OfmVld=6'b001000 one cycle later with data 0xA5...; other cores stay idle.
- Core 2 held not ready; 3 beats tag=2 -> beats 1 and 2 accepted; 3rd sees MIFMIC_OfmRdy=0. Raise core 2 ready -> beats delivered in order 1,2,3.
- Core 2 full and stalled; next beat tag=5 -> accepted immediately and delivered to core 5 (no head-of-line blocking).
- Beat with tag=7 (POOL_CORE=6) -> accepted; no core valid; DropCnt=1; Err=1. 300 such beats -> DropCnt=255.
- RSP_CREDIT_CHK_EN defined: beat tag=1 with no prior ReqAcc[1] -> dropped, Err=1. Then ReqAcc[1] pulse, then beat tag=1 -> delivered, oc[1] returns to 0.

Source files
------------

// File: rtl/mic_rsp_dmx.sv
// rtl/mic_rsp_dmx.sv - port-tagged response demux with a 2-entry FWFT buffer per pool core
// Optional outstanding-credit checking is built when RSP_CREDIT_CHK_EN is defined.
module mic_rsp_dmx #(
  parameter int POOL_CORE      = 6,
  parameter int POOL_COMP_CORE = 64,
  parameter int ACT_WIDTH      = 8,
  parameter int MAX_OUTS       = 4,
  localparam int PORT_W        = $clog2(POOL_CORE),
  localparam int DW            = ACT_WIDTH*POOL_COMP_CORE
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic [PORT_W+DW-1:0]    MICMIF_Ofm,
  input  logic                    MICMIF_OfmVld,
  output logic                    MIFMIC_OfmRdy,
  output logic [DW*POOL_CORE-1:0] MIFPOL_Ofm,
  output logic [POOL_CORE-1:0]    MIFPOL_OfmVld,
  input  logic [POOL_CORE-1:0]    POLMIF_OfmRdy,
  input  logic [POOL_CORE-1:0]    POLMIF_ReqAcc,
  output logic [7:0]              MIFPOL_DropCnt,
  output logic                    MIFPOL_Err
);

  localparam int OCW = $clog2(MAX_OUTS+1);

  logic [PORT_W-1:0]    tag;
  logic [DW-1:0]        din;
  logic [POOL_CORE-1:0] hit;
  logic [POOL_CORE-1:0] full;
  logic [POOL_CORE-1:0] credit_ok;
  logic [POOL_CORE-1:0] push;
  logic                 accept;
  logic                 drop;
  logic                 credit_err;

  assign tag = MICMIF_Ofm[PORT_W+DW-1:DW];
  assign din = MICMIF_Ofm[DW-1:0];

  // Only a routable beat whose buffer is full can stall; everything else drains.
  assign MIFMIC_OfmRdy = !Reset && !(|(hit & credit_ok & full));
  assign accept        = MICMIF_OfmVld && MIFMIC_OfmRdy;
  assign push          = {POOL_CORE{accept}} & hit & credit_ok;
  assign drop          = accept && !(|(hit & credit_ok));

  for (genvar gi = 0; gi < POOL_CORE; gi++) begin : g_core
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic [1:0]    cnt;
    logic          pop;

    assign hit[gi]                  = (tag == PORT_W'(gi));
    assign full[gi]                 = cnt[1];
    assign pop                      = (cnt != 2'd0) && POLMIF_OfmRdy[gi];
    assign MIFPOL_OfmVld[gi]        = (cnt != 2'd0);
    assign MIFPOL_Ofm[DW*gi +: DW]  = e0;

    // A push never coincides with cnt==2, so push+pop always means cnt==1.
    always_ff @(posedge clk) begin
      if (Reset) begin
        cnt <= 2'd0;
      end else if (push[gi] && pop) begin
        e0 <= din;
      end else if (pop) begin
        e0  <= e1;
        cnt <= cnt - 2'd1;
      end else if (push[gi]) begin
        if (cnt == 2'd0) e0 <= din;
        else             e1 <= din;
        cnt <= cnt + 2'd1;
      end
    end
  end

`ifdef RSP_CREDIT_CHK_EN
  logic [POOL_CORE-1:0] oc_ovf;

  for (genvar gi = 0; gi < POOL_CORE; gi++) begin : g_credit
    logic [OCW-1:0] oc;
    logic           inc;

    assign inc           = POLMIF_ReqAcc[gi];
    assign credit_ok[gi] = (oc != '0);
    assign oc_ovf[gi]    = inc && !push[gi] && (oc == OCW'(MAX_OUTS));

    always_ff @(posedge clk) begin
      if (Reset) begin
        oc <= '0;
      end else if (inc && !push[gi] && !oc_ovf[gi]) begin
        oc <= oc + 1'b1;
      end else if (push[gi] && !inc) begin
        oc <= oc - 1'b1;
      end
    end
  end

  assign credit_err = |oc_ovf;
`else
  logic unused_credit;

  assign credit_ok     = '1;
  assign credit_err    = 1'b0;
  assign unused_credit = ^{POLMIF_ReqAcc, OCW'(MAX_OUTS)};
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      MIFPOL_DropCnt <= 8'd0;
      MIFPOL_Err     <= 1'b0;
    end else begin
      if (drop && MIFPOL_DropCnt != 8'hFF) MIFPOL_DropCnt <= MIFPOL_DropCnt + 8'd1;
      if (drop || credit_err)              MIFPOL_Err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mic_rsp_dmx.sv
// tb/tb_mic_rsp_dmx.sv - scoreboard bench for mic_rsp_dmx with a queue-based reference model
module tb_mic_rsp_dmx;
  localparam int PC = 6;
  localparam int PW = 3;
  localparam int DW = 512;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              Reset;
  logic [PW+DW-1:0]  MICMIF_Ofm;
  logic              MICMIF_OfmVld;
  logic              MIFMIC_OfmRdy;
  logic [DW*PC-1:0]  MIFPOL_Ofm;
  logic [PC-1:0]     MIFPOL_OfmVld;
  logic [PC-1:0]     POLMIF_OfmRdy;
  logic [PC-1:0]     POLMIF_ReqAcc;
  logic [7:0]        MIFPOL_DropCnt;
  logic              MIFPOL_Err;

  mic_rsp_dmx dut (
    .clk(clk), .Reset(Reset),
    .MICMIF_Ofm(MICMIF_Ofm), .MICMIF_OfmVld(MICMIF_OfmVld), .MIFMIC_OfmRdy(MIFMIC_OfmRdy),
    .MIFPOL_Ofm(MIFPOL_Ofm), .MIFPOL_OfmVld(MIFPOL_OfmVld), .POLMIF_OfmRdy(POLMIF_OfmRdy),
    .POLMIF_ReqAcc(POLMIF_ReqAcc), .MIFPOL_DropCnt(MIFPOL_DropCnt), .MIFPOL_Err(MIFPOL_Err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [DW-1:0] exp_q [PC][$];
  bit          mon_en = 1'b0;
  int          exp_drop = 0;
  bit          exp_err = 1'b0;
  int          exp_oc [PC];
  bit          pend_v = 1'b0;
  int          pend_t = 0;
  logic [DW-1:0] pend_d;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  // One clock of stimulus; the model predicts ready from what it holds before this edge.
  task automatic step(input bit v, input int t, input logic [DW-1:0] d,
                      input logic [PC-1:0] crdy, input logic [PC-1:0] racc, output bit acc);
    logic [PW-1:0] tg;
    bit ok;
    bit er;
    @(posedge clk); #1;
    if (pend_v) exp_q[pend_t].push_back(pend_d);
    pend_v = 1'b0;
    tg = t[PW-1:0];
    MICMIF_OfmVld = v;
    MICMIF_Ofm    = {tg, d};
    POLMIF_OfmRdy = crdy;
    POLMIF_ReqAcc = racc;
    #1;
    chk("drop_cnt", MIFPOL_DropCnt, exp_drop);
    chk("err", MIFPOL_Err, exp_err);
`ifdef RSP_CREDIT_CHK_EN
    ok = (t < PC) && (exp_oc[t] > 0);
`else
    ok = (t < PC);
`endif
    er  = ok ? (exp_q[t].size() < 2) : 1'b1;
    acc = v && er;
    chk("ofm_rdy", MIFMIC_OfmRdy, er);
    if (acc && ok) begin
      pend_v = 1'b1; pend_t = t; pend_d = d;
    end else if (acc) begin
      if (exp_drop < 255) exp_drop++;
      exp_err = 1'b1;
    end
`ifdef RSP_CREDIT_CHK_EN
    for (int i = 0; i < PC; i++) begin
      bit dec;
      dec = acc && ok && (t == i);
      if (racc[i] && !dec) begin
        if (exp_oc[i] == MO) exp_err = 1'b1;
        else exp_oc[i]++;
      end else if (dec && !racc[i]) begin
        exp_oc[i]--;
      end
    end
`endif
  endtask

  task automatic give_credit(input logic [PC-1:0] m);
`ifdef RSP_CREDIT_CHK_EN
    bit a;
    step(1'b0, 0, '0, '1, m, a);
`else
    if (m == '0) checks = checks;
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    mon_en = 1'b0;
    pend_v = 1'b0;
    Reset = 1'b1;
    MICMIF_OfmVld = 1'b1;
    POLMIF_ReqAcc = '0;
    repeat (2) begin
      @(posedge clk); #2;
      chk("rst_rdy", MIFMIC_OfmRdy, 0);
      chk("rst_vld", MIFPOL_OfmVld, 0);
      chk("rst_drop", MIFPOL_DropCnt, 0);
      chk("rst_err", MIFPOL_Err, 0);
    end
    Reset = 1'b0;
    MICMIF_OfmVld = 1'b0;
    for (int i = 0; i < PC; i++) begin
      exp_q[i].delete();
      exp_oc[i] = 0;
    end
    exp_drop = 0;
    exp_err  = 1'b0;
    mon_en   = 1'b1;
  endtask

  // Monitor: every core's valid must match the model, and each handshake pops the model.
  always @(posedge clk) begin
    #3;
    if (mon_en) begin
      for (int i = 0; i < PC; i++) begin
        chk($sformatf("vld_core%0d", i), MIFPOL_OfmVld[i], exp_q[i].size() != 0);
        if (MIFPOL_OfmVld[i] && POLMIF_OfmRdy[i] && exp_q[i].size() != 0) begin
          checks++;
          if (MIFPOL_Ofm[DW*i +: DW] !== exp_q[i][0]) begin
            errors++;
            $display("FAIL data_core%0d: got %h expected %h", i, MIFPOL_Ofm[DW*i +: DW], exp_q[i][0]);
          end
          void'(exp_q[i].pop_front());
        end
      end
    end
  end

  initial begin
    bit a;
    int tries;
    logic [DW-1:0] d1, d2, d3, d5, pat;
    for (int i = 0; i < PC; i++) exp_oc[i] = 0;
    Reset = 1'b1;
    MICMIF_OfmVld = 1'b1;
    MICMIF_Ofm = '0;
    POLMIF_OfmRdy = '1;
    POLMIF_ReqAcc = '0;
    do_reset();

    // Single beat to core 3 shows up on core 3 only, one cycle later.
    pat = {64{8'hA5}};
    give_credit(6'b001000);
    step(1'b1, 3, pat, '1, '0, a);
    step(1'b0, 0, '0, '1, '0, a);
    chk("vld_onehot_t3", MIFPOL_OfmVld, 6'b001000);
    step(1'b0, 0, '0, '1, '0, a);

    // Core 2 stalled: two beats fit, the third must wait; core 5 is not blocked.
    d1 = rand_data(); d2 = rand_data(); d3 = rand_data(); d5 = rand_data();
    repeat (3) give_credit(6'b000100);
    give_credit(6'b100000);
    step(1'b1, 2, d1, 6'b111011, '0, a);
    step(1'b1, 2, d2, 6'b111011, '0, a);
    step(1'b1, 2, d3, 6'b111011, '0, a);
    chk("stall_rdy", MIFMIC_OfmRdy, 0);
    step(1'b1, 5, d5, 6'b111011, '0, a);
    chk("no_hol_rdy", MIFMIC_OfmRdy, 1);
    step(1'b0, 0, '0, 6'b111011, '0, a);
    tries = 0;
    a = 1'b0;
    while (!a && tries < 8) begin
      step(1'b1, 2, d3, '1, '0, a);
      tries++;
    end
    chk("stall_release_accept", a, 1);
    repeat (4) step(1'b0, 0, '0, '1, '0, a);

    // Invalid tag drains, counts, and saturates.
    step(1'b1, 7, rand_data(), '1, '0, a);
    step(1'b0, 0, '0, '1, '0, a);
    chk("drop_first", MIFPOL_DropCnt, 1);
    chk("err_first", MIFPOL_Err, 1);
    repeat (299) step(1'b1, 7, rand_data(), '1, '0, a);
    step(1'b0, 0, '0, '1, '0, a);
    chk("drop_sat", MIFPOL_DropCnt, 255);

`ifdef RSP_CREDIT_CHK_EN
    do_reset();
    step(1'b1, 1, rand_data(), '1, '0, a);
    step(1'b0, 0, '0, '1, '0, a);
    chk("nocredit_err", MIFPOL_Err, 1);
    give_credit(6'b000010);
    step(1'b1, 1, rand_data(), '1, '0, a);
    repeat (2) step(1'b0, 0, '0, '1, '0, a);
`endif

    // Randomized traffic, with a mid-stream reset.
    for (int n = 0; n < 1600; n++) begin
      logic [PC-1:0] cr, ra;
      cr = PC'($urandom);
      ra = PC'($urandom & $urandom);
      if (n == 800) do_reset();
      step(($urandom % 4) != 0, $urandom % 8, rand_data(), cr, ra, a);
    end
    repeat (6) step(1'b0, 0, '0, '1, '0, a);
    for (int i = 0; i < PC; i++) chk($sformatf("drain_core%0d", i), exp_q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
